// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO accumulator: op encodings and default widths.
package hilo_pkg;

  localparam int unsigned HILO_DATA_W = 32;
  localparam int unsigned HILO_OP_W   = 3;

  // Codes 6 and 7 are reserved and behave as NOP.
  typedef enum logic [HILO_OP_W-1:0] {
    HILO_NOP     = 3'd0,
    HILO_WR_BOTH = 3'd1,
    HILO_WR_HI   = 3'd2,
    HILO_WR_LO   = 3'd3,
    HILO_MADD    = 3'd4,
    HILO_MSUB    = 3'd5
  } hilo_op_e;

endpackage

// File: rtl/hilo_addsub.sv
// Combinational double-width add/subtract of the {hi,lo} pair and a product.
module hilo_addsub #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] prod,
  input  logic             sub,
  output logic [WIDTH-1:0] res
);

  // Wraps modulo 2^WIDTH; LO carry/borrow flows into HI naturally.
  always_comb begin
    res = sub ? (acc - prod) : (acc + prod);
  end

endmodule

// File: rtl/hilo_acc.sv
// HI/LO register pair with selective writes and a 2-cycle MADD/MSUB path.
// Define HILO_BYPASS_EN to forward next-edge values onto hi_rd/lo_rd.
module hilo_acc
  import hilo_pkg::*;
#(
  parameter int unsigned DATA_W = HILO_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 op_valid,
  input  logic [HILO_OP_W-1:0] op,
  input  logic [DATA_W-1:0]    hi_in,
  input  logic [DATA_W-1:0]    lo_in,
  output logic                 op_ready,
  output logic                 busy,
  output logic [DATA_W-1:0]    hi_out,
  output logic [DATA_W-1:0]    lo_out,
  output logic [DATA_W-1:0]    hi_rd,
  output logic [DATA_W-1:0]    lo_rd
);

  logic [2*DATA_W-1:0] prod_q;
  logic                sub_q;
  logic [2*DATA_W-1:0] acc_res;
  logic                accept;
  hilo_op_e            op_e;

  assign op_e     = hilo_op_e'(op);
  assign op_ready = ~busy;
  assign accept   = op_valid & ~busy;

  hilo_addsub #(
    .WIDTH(2*DATA_W)
  ) u_addsub (
    .acc (({hi_out, lo_out})),
    .prod(prod_q),
    .sub (sub_q),
    .res (acc_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_out <= '0;
      lo_out <= '0;
      busy   <= 1'b0;
      prod_q <= '0;
      sub_q  <= 1'b0;
    end else if (busy) begin
      {hi_out, lo_out} <= acc_res;
      busy             <= 1'b0;
    end else if (accept) begin
      case (op_e)
        HILO_WR_BOTH: begin
          hi_out <= hi_in;
          lo_out <= lo_in;
        end
        HILO_WR_HI: hi_out <= hi_in;
        HILO_WR_LO: lo_out <= lo_in;
        HILO_MADD, HILO_MSUB: begin
          prod_q <= {hi_in, lo_in};
          sub_q  <= (op_e == HILO_MSUB);
          busy   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    hi_rd = hi_out;
    lo_rd = lo_out;
`ifdef HILO_BYPASS_EN
    if (busy) begin
      {hi_rd, lo_rd} = acc_res;
    end else if (accept) begin
      case (op_e)
        HILO_WR_BOTH: begin
          hi_rd = hi_in;
          lo_rd = lo_in;
        end
        HILO_WR_HI: hi_rd = hi_in;
        HILO_WR_LO: lo_rd = lo_in;
        default: ;
      endcase
    end
`endif
  end

endmodule

// File: tb/tb_hilo_acc.sv
// Self-checking bench for hilo_acc: directed plan steps plus random ops vs a value model.
module tb_hilo_acc;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          op_valid;
  logic [2:0]    op;
  logic [W-1:0]  hi_in, lo_in;
  logic          op_ready, busy;
  logic [W-1:0]  hi_out, lo_out, hi_rd, lo_rd;

  hilo_acc #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op),
    .hi_in(hi_in), .lo_in(lo_in), .op_ready(op_ready), .busy(busy),
    .hi_out(hi_out), .lo_out(lo_out), .hi_rd(hi_rd), .lo_rd(lo_rd)
  );

  always #5 clk = ~clk;

  // Model: architectural value as one 64-bit number plus a pending accumulate.
  logic [2*W-1:0] m_val;
  logic [2*W-1:0] m_pend;
  logic           m_is_sub;
  logic           m_busy;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Value the pair will hold after the next edge, ignoring reset.
  function automatic logic [2*W-1:0] model_next();
    logic [2*W-1:0] v;
    v = m_val;
    if (m_busy)
      v = m_is_sub ? m_val - m_pend : m_val + m_pend;
    else if (op_valid) begin
      if (op == 3'd1) v = {hi_in, lo_in};
      else if (op == 3'd2) v = {hi_in, m_val[W-1:0]};
      else if (op == 3'd3) v = {m_val[2*W-1:W], lo_in};
    end
    return v;
  endfunction

  task automatic tick();
    logic [2*W-1:0] nxt;
    #1;
    nxt = model_next();
    check("op_ready", {63'd0, op_ready}, {63'd0, ~m_busy});
    if (!rst) begin
`ifdef HILO_BYPASS_EN
      check("rd_bypass", {hi_rd, lo_rd}, nxt);
`else
      check("rd", {hi_rd, lo_rd}, m_val);
`endif
    end
    @(posedge clk);
    if (rst) begin
      m_val = '0; m_pend = '0; m_is_sub = 1'b0; m_busy = 1'b0;
    end else if (m_busy) begin
      m_val = nxt; m_busy = 1'b0;
    end else begin
      m_val = nxt;
      if (op_valid && (op == 3'd4 || op == 3'd5)) begin
        m_pend = {hi_in, lo_in}; m_is_sub = (op == 3'd5); m_busy = 1'b1;
      end
    end
    #1;
    check("hilo_out", {hi_out, lo_out}, m_val);
    check("busy", {63'd0, busy}, {63'd0, m_busy});
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [W-1:0] h, input logic [W-1:0] l);
    op_valid = v; op = o; hi_in = h; lo_in = l;
  endtask

  initial begin
    rst = 1'b1;
    m_val = '0; m_pend = '0; m_is_sub = 1'b0; m_busy = 1'b0;
    drive(1'b0, 3'd0, '0, '0);
    tick(); tick();
    check("reset_val", {hi_out, lo_out}, 64'h0);
    rst = 1'b0;

    // 1. WR_BOTH
    drive(1'b1, 3'd1, 32'h12345678, 32'h9ABCDEF0); tick();
    check("wr_both", {hi_out, lo_out}, 64'h12345678_9ABCDEF0);
    // 2. selective writes
    drive(1'b1, 3'd2, 32'hAAAA0000, 32'hDEADBEEF); tick();
    check("wr_hi", {hi_out, lo_out}, 64'hAAAA0000_9ABCDEF0);
    drive(1'b1, 3'd3, 32'hFFFF0000, 32'h1); tick();
    check("wr_lo", {hi_out, lo_out}, 64'hAAAA0000_00000001);
    // 3. MADD carry into HI
    drive(1'b1, 3'd1, 32'h0, 32'hFFFFFFFF); tick();
    drive(1'b1, 3'd4, 32'h0, 32'h1); tick();
    check("madd_busy", {63'd0, busy}, 64'd1);
    drive(1'b0, 3'd0, '0, '0); tick();
    check("madd_carry", {hi_out, lo_out}, 64'h00000001_00000000);
    // 4. MSUB borrow wrap
    drive(1'b1, 3'd1, 32'h0, 32'h0); tick();
    drive(1'b1, 3'd5, 32'h0, 32'h1); tick();
    drive(1'b0, 3'd0, '0, '0); tick();
    check("msub_wrap", {hi_out, lo_out}, 64'hFFFFFFFF_FFFFFFFF);
    // 5a. WR_BOTH held during busy lands on top of the MADD result
    drive(1'b1, 3'd1, 32'h0, 32'h10); tick();
    drive(1'b1, 3'd4, 32'h0, 32'h5); tick();
    drive(1'b1, 3'd1, 32'h11111111, 32'h22222222); tick();
    check("interlock_madd", {hi_out, lo_out}, 64'h00000000_00000015);
    tick();
    check("interlock_wr", {hi_out, lo_out}, 64'h11111111_22222222);
    // 5b. reset mid-accumulate
    drive(1'b1, 3'd4, 32'h1, 32'h1); tick();
    drive(1'b0, 3'd0, '0, '0); rst = 1'b1; tick(); rst = 1'b0;
    check("rst_midacc", {hi_out, lo_out, 31'd0, busy}, 96'd0);
    // 6. read port after WR_LO (bypass value checked inside tick before the edge)
    drive(1'b1, 3'd3, 32'h0, 32'h55); tick();
    drive(1'b0, 3'd0, '0, '0); tick();
    check("lo_rd_after", {32'd0, lo_rd}, 64'h55);

    // Random ops, including reserved codes, held ops under busy and rare resets.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), $urandom, $urandom);
      if ((i % 7) == 0) begin hi_in = '1; lo_in = '1; end
      rst = ($urandom_range(0, 40) == 0);
      tick();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hilo_acc.md
Name: hilo_acc

Overview:
Parametrised successor to the plain HI/LO register pair: it holds the 2×DATA_W HI/LO state for the execute/writeback path.
- Adds selective writes (MTHI/MTLO), a 2-cycle multiply-accumulate/subtract (MADD/MSUB) path with a busy interlock, and an optional same-cycle read bypass.
- Sits after the multiplier. The writeback stage drives ops; the decode/execute stage reads hi_rd/lo_rd.

Parameters:
DATA_W, 32, width of each of HI and LO.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high (RstEnable = 1)
op_valid  in  1  op request this cycle
op  in  3  operation code (see Behaviour)
hi_in  in  DATA_W  HI write data / upper half of product
lo_in  in  DATA_W  LO write data / lower half of product
op_ready  out  1  op accepted when op_valid & op_ready
busy  out  1  accumulate in flight
hi_out  out  DATA_W  architectural HI register
lo_out  out  DATA_W  architectural LO register
hi_rd  out  DATA_W  HI read port for consumers
lo_rd  out  DATA_W  LO read port for consumers

Behaviour:
- Reset: hi_out=0, lo_out=0, busy=0, pending op/operand cleared. op_ready=1 in the cycle after reset.
- Op codes:
  - 0 NOP
  - 1 WR_BOTH
  - 2 WR_HI
  - 3 WR_LO
  - 4 MADD
  - 5 MSUB
  - 6, 7 reserved: accepted, act as NOP.
- op_ready = ~busy (combinational). When op_valid & ~op_ready, the op is ignored and upstream must hold it.
- WR_BOTH: hi_out<=hi_in, lo_out<=lo_in at the accepting edge. Latency 1.
- WR_HI: only hi_out is updated. WR_LO: only lo_out is updated.
- MADD/MSUB, two stages:
  - Accepting edge: latches P={hi_in,lo_in} (2·DATA_W) and the add/sub flag into stage 1; busy<=1.
  - Next edge: {hi_out,lo_out} <= {hi_out,lo_out} ± P, modulo 2^(2·DATA_W). The carry/borrow from LO propagates into HI. No overflow flag, no saturation.
  - busy<=0 on the same edge. Result is visible on hi_out/lo_out 2 edges after acceptance.
  - Back-to-back accumulates: the second op is accepted the cycle busy drops, giving one accepted accumulate per 2 cycles.
- Signedness is resolved by the multiplier. This block does plain 2·DATA_W add/sub.
- No write can collide with an in-flight accumulate, because op_ready=0 while busy.
- rst asserted mid-accumulate: the pending op is discarded, all registers go to 0, busy=0.
- hi_rd/lo_rd: equal hi_out/lo_out (no bypass build).

Optional Feature:
HILO_BYPASS_EN:
- Defined:
  - hi_rd/lo_rd combinationally return the value being written at the next edge: for an accepted WR_BOTH, WR_HI or WR_LO, the written half takes the new value and the other half keeps hi_out/lo_out; on a completing accumulate (busy=1), both halves take the sum/difference.
  - Otherwise hi_rd/lo_rd equal hi_out/lo_out.
- Undefined: hi_rd=hi_out, lo_rd=lo_out. Consumers see writes one cycle later.

Decomposition:
- Package hilo_pkg: op code constants (HILO_NOP, HILO_WR_BOTH, HILO_WR_HI, HILO_WR_LO, HILO_MADD, HILO_MSUB), default DATA_W, op field width 3.
- Sub-module hilo_addsub: combinational 2·DATA_W add/sub of {hi,lo} and P, selected by the sub flag. Shared by the update path and the bypass path.

Test Plan:
1. Reset/WR_BOTH: rst high 2 cycles, then WR_BOTH hi_in=0x12345678, lo_in=0x9ABCDEF0 -> hi_out=0, lo_out=0 out of reset; after 1 edge, hi_out=0x12345678, lo_out=0x9ABCDEF0.
2. Selective write: from (1), WR_HI hi_in=0xAAAA0000 -> hi_out=0xAAAA0000, lo_out unchanged 0x9ABCDEF0. Then WR_LO lo_in=0x1 -> lo_out=1, hi_out unchanged.
3. MADD carry: hi=0, lo=0xFFFFFFFF; MADD hi_in=0, lo_in=1 -> busy=1 and op_ready=0 for 1 cycle; after 2 edges, hi_out=1, lo_out=0.
4. MSUB borrow/wrap: hi=lo=0; MSUB hi_in=0, lo_in=1 -> hi_out=lo_out=0xFFFFFFFF.
5. Interlock/reset: MADD accepted, WR_BOTH held valid next cycle -> WR_BOTH is not accepted until busy=0, then applied on top of the MADD result. Separately, rst asserted while busy=1 -> hi_out=lo_out=0, busy=0, accumulate lost.
6. Bypass (HILO_BYPASS_EN): WR_LO lo_in=0x55 -> lo_rd=0x55 in the same cycle. Completing MADD -> hi_rd/lo_rd show the sum one cycle before hi_out/lo_out. Without the macro, lo_rd=0x55 only after the edge.
